// File: rtl/hexd_if.sv
// Hex-display write port: a data word plus a single-cycle write strobe.
// Handshake: there is no ready; every cycle with i_hexd_wren=1 transfers
// i_hexd_data and the receiver always accepts it.
interface hexd_if;
    logic [15:0] i_hexd_data;
    logic        i_hexd_wren;

    modport master (
        output i_hexd_data,
        output i_hexd_wren
    );

    modport slave (
        input i_hexd_data,
        input i_hexd_wren
    );
endinterface

// File: rtl/hexd_scan.sv
// Four-digit multiplexed seven-segment driver. Writes land in a pending
// buffer and are promoted to the displayed value only at frame boundaries,
// so a frame never mixes nibbles from two different writes. Each digit slot
// opens with a blanking interval to suppress ghosting between digits.
module hexd_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    hexd_if.slave      hexd,
    output logic [3:0] o_anodes,
    output logic [7:0] o_segs,
    output logic       o_frame
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_L  = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [15:0]   shown_q, shown_d;
    logic [3:0]    anodes_q, anodes_d;
    logic [7:0]    segs_q, segs_d;
    logic          frame_q, frame_d;

    logic          cnt_wrap;
    logic          boundary;
    logic [3:0]    nibble;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            default: f = 7'h0E;
        endcase
        return f;
    endfunction

    // Slot timing, write buffering and registered output decode.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        shown_d  = shown_q;
        anodes_d = 4'b1111;
        segs_d   = 8'hFF;
        frame_d  = 1'b0;

        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = cnt_wrap && (idx_q == 2'd3);
        nibble   = 4'(shown_q >> {idx_q, 2'b00});

        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Last write in a frame wins; pend_v marks that pend holds fresh data.
        if (hexd.i_hexd_wren) begin
            pend_d   = hexd.i_hexd_data;
            pend_v_d = 1'b1;
        end

        // A write on the boundary cycle itself bypasses the pending buffer.
        if (boundary) begin
            pend_v_d = 1'b0;
            if (hexd.i_hexd_wren) begin
                shown_d = hexd.i_hexd_data;
            end else if (pend_v_q) begin
                shown_d = pend_q;
            end
        end

        if (cnt_q >= BLANK_L) begin
            anodes_d = ~(4'b0001 << idx_q);
            segs_d   = {1'b1, font(nibble)};
        end

        frame_d = boundary;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
            shown_q  <= 16'h0000;
            anodes_q <= 4'b1111;
            segs_q   <= 8'hFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            shown_q  <= shown_d;
            anodes_q <= anodes_d;
            segs_q   <= segs_d;
            frame_q  <= frame_d;
        end
    end

    assign o_anodes = anodes_q;
    assign o_segs   = segs_q;
    assign o_frame  = frame_q;

endmodule

// File: tb/tb_hexd_scan.sv
// Bench for hexd_scan with SCAN_DIV=8, BLANK_CYCLES=2. Cycle t is the
// window ending at the t-th rising edge after reset release; outputs for
// cycle t are sampled on the falling edge just before that rising edge,
// and inputs for cycle t are driven at the same falling edge.
module tb_hexd_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] o_anodes;
  logic [7:0] o_segs;
  logic       o_frame;

  hexd_if hexd ();

  hexd_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .hexd     (hexd),
    .o_anodes (o_anodes),
    .o_segs   (o_segs),
    .o_frame  (o_frame)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // scoreboard entry: {cycle[15:0], anodes[3:0], segs[7:0], frame}
  logic [28:0] exp_q[$];
  logic [28:0] e;
  int n_checks;
  int n_fail;

  // full active-low segment byte {dp,g..a} for each hex digit
  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  task automatic push_reset(input int c);
    exp_q.push_back({16'(c), 4'b1111, 8'hFF, 1'b0});
  endtask

  // Expected outputs for the frame whose boundary pulse precedes cycle base+1:
  // cycles base+1 .. base+32, truncated at 'last'.
  task automatic push_frame(input int base, input logic [15:0] val, input int last);
    for (int k = 0; k < 4; k++) begin
      for (int s = 1; s <= SD; s++) begin
        int c;
        logic [3:0] an;
        logic [7:0] sg;
        c = base + k * SD + s;
        if (c <= last) begin
          if (s <= BC) begin
            an = 4'b1111;
            sg = 8'hFF;
          end else begin
            an = ~(4'b0001 << k);
            sg = seg_of(val[k*4 +: 4]);
          end
          exp_q.push_back({16'(c), an, sg, (k == 3 && s == SD)});
        end
      end
    end
  endtask

  // driver: three reset edges, loop iteration t=0 then releases reset
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    hexd.i_hexd_wren = 1'b0;
    hexd.i_hexd_data = 16'h0000;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic drive(input logic rst_v, input logic wr, input logic [15:0] d);
    i_rst_n = rst_v;
    hexd.i_hexd_wren = wr;
    hexd.i_hexd_data = wr ? d : 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic test_reset();
    exp_q.delete();
    do_reset();
    push_reset(0);
    push_frame(0, 16'h0000, 64);
    push_frame(32, 16'h0000, 64);
    for (int t = 0; t <= 64; t++) begin
      @(negedge i_clk);
      if (exp_q.size() != 0 && int'(exp_q[0][28:13]) == t) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_anodes, o_segs, o_frame} !== e[12:0]) begin
          n_fail++;
          $display("FAIL reset cyc=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                   t, o_anodes, o_segs, o_frame, e[12:9], e[8:1], e[0]);
        end
      end
      drive(1'b1, 1'b0, 16'h0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_write();
    exp_q.delete();
    do_reset();
    push_reset(0);
    push_frame(0, 16'h0000, 64);
    push_frame(32, 16'h1234, 64);
    for (int t = 0; t <= 64; t++) begin
      @(negedge i_clk);
      if (exp_q.size() != 0 && int'(exp_q[0][28:13]) == t) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_anodes, o_segs, o_frame} !== e[12:0]) begin
          n_fail++;
          $display("FAIL write_1234 cyc=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                   t, o_anodes, o_segs, o_frame, e[12:9], e[8:1], e[0]);
        end
      end
      drive(1'b1, (t == 5), 16'h1234);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_last_write_wins();
    exp_q.delete();
    do_reset();
    push_reset(0);
    push_frame(0, 16'h0000, 64);
    push_frame(32, 16'h5555, 64);
    for (int t = 0; t <= 64; t++) begin
      @(negedge i_clk);
      if (exp_q.size() != 0 && int'(exp_q[0][28:13]) == t) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_anodes, o_segs, o_frame} !== e[12:0]) begin
          n_fail++;
          $display("FAIL last_write cyc=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                   t, o_anodes, o_segs, o_frame, e[12:9], e[8:1], e[0]);
        end
      end
      if (t == 20) begin
        n_checks++;
        if (dut.pend_v_q !== 1'b1) begin
          n_fail++;
          $display("FAIL last_write_pend_v got %b want 1", dut.pend_v_q);
        end
      end
      if (t == 40) begin
        n_checks++;
        if (dut.pend_v_q !== 1'b0) begin
          n_fail++;
          $display("FAIL last_write_pend_clr got %b want 0", dut.pend_v_q);
        end
      end
      if (t == 10) drive(1'b1, 1'b1, 16'hAAAA);
      else if (t == 12) drive(1'b1, 1'b1, 16'h5555);
      else drive(1'b1, 1'b0, 16'h0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL last_write_drain got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_boundary_bypass();
    exp_q.delete();
    do_reset();
    push_reset(0);
    push_frame(0, 16'h0000, 96);
    push_frame(32, 16'hBEEF, 96);
    push_frame(64, 16'hBEEF, 96);
    for (int t = 0; t <= 96; t++) begin
      @(negedge i_clk);
      if (exp_q.size() != 0 && int'(exp_q[0][28:13]) == t) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_anodes, o_segs, o_frame} !== e[12:0]) begin
          n_fail++;
          $display("FAIL bypass cyc=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                   t, o_anodes, o_segs, o_frame, e[12:9], e[8:1], e[0]);
        end
      end
      if (t == 33 || t == 70) begin
        n_checks++;
        if (dut.pend_v_q !== 1'b0) begin
          n_fail++;
          $display("FAIL bypass_pend_v cyc=%0d got %b want 0", t, dut.pend_v_q);
        end
      end
      drive(1'b1, (t == 31), 16'hBEEF);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bypass_drain got %0d left want 0", exp_q.size());
    end
  endtask

  // reset held during cycle 45; old cycle 46 becomes the new cycle 0
  task automatic test_mid_reset();
    exp_q.delete();
    do_reset();
    push_reset(0);
    push_frame(0, 16'h0000, 45);
    push_frame(32, 16'hFFFF, 45);
    push_reset(46);
    push_frame(46, 16'h0000, 110);
    push_frame(78, 16'h0000, 110);
    for (int t = 0; t <= 110; t++) begin
      @(negedge i_clk);
      if (exp_q.size() != 0 && int'(exp_q[0][28:13]) == t) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({o_anodes, o_segs, o_frame} !== e[12:0]) begin
          n_fail++;
          $display("FAIL mid_reset cyc=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                   t, o_anodes, o_segs, o_frame, e[12:9], e[8:1], e[0]);
        end
      end
      if (t == 5) drive(1'b1, 1'b1, 16'hFFFF);
      else if (t == 40) drive(1'b1, 1'b1, 16'h0001);
      else drive((t != 45), 1'b0, 16'h0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_drain got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    i_rst_n = 1'b0;
    hexd.i_hexd_wren = 1'b0;
    hexd.i_hexd_data = 16'h0000;
    test_reset();
    test_write();
    test_last_write_wins();
    test_boundary_bypass();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
